// File: rtl/line_fetch_pkg.sv
// Shared types and constants for the line_fetch scan-out stage.
package line_fetch_pkg;

    // IDLE: no fetch | FETCH: VRAM -> back buffer | DONE: back buffer full, waiting for swap
    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_FETCH = 2'd1,
        FS_DONE  = 2'd2
    } fetch_state_e;

    localparam logic BUF_A = 1'b0;
    localparam logic BUF_B = 1'b1;

    function automatic int ptr_width(input int hpix);
        return $clog2(hpix) + 1;
    endfunction

endpackage

// File: rtl/line_fetch_ram.sv
// Ping-pong line buffer: simple dual-port RAM, sync write and sync read, buffer select is the address MSB.
module line_fetch_ram #(
    parameter int PIX_W = 16,
    parameter int IDX_W = 9
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic             i_wsel,
    input  logic [IDX_W-1:0] i_widx,
    input  logic [PIX_W-1:0] i_wdata,
    input  logic             i_re,
    input  logic             i_rsel,
    input  logic [IDX_W-1:0] i_ridx,
    output logic [PIX_W-1:0] o_rdata
);

    localparam int DEPTH = 2 ** (IDX_W + 1);

    logic [PIX_W-1:0] r_mem [DEPTH];
    logic [PIX_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[{i_wsel, i_widx}] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[{i_rsel, i_ridx}];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/line_fetch.sv
// Line fetch / scan-out stage: VRAM line fetch into a ping-pong buffer, pixel stream aligned to the dot enable.
// Optional build macro LINE_FETCH_HFLIP_EN mirrors the scan-out order (fetch order unchanged).
module line_fetch
    import line_fetch_pkg::*;
#(
    parameter int                PIX_W       = 16,
    parameter int                HPIX        = 320,
    parameter int                ADDR_W      = 18,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                LINE_STRIDE = 320,
    parameter logic [PIX_W-1:0]  BORDER      = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ex_vwsav,
    input  logic              i_ex_veav,
    input  logic              i_ex_hwsav,
    input  logic              i_ex_heav,
    input  logic              i_ex_hc,
    input  logic              i_ex_vc,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_ack,
    input  logic [PIX_W-1:0]  i_mem_rdata,
    output logic              o_pix_de,
    output logic [PIX_W-1:0]  o_pix_data,
    output logic              o_underrun
);

    localparam int                PTR_W    = ptr_width(HPIX);
    localparam int                IDX_W    = PTR_W - 1;
    localparam logic [PTR_W-1:0]  HPIX_P   = PTR_W'(HPIX);
    localparam logic [PTR_W-1:0]  LAST_P   = PTR_W'(HPIX - 1);
    localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(LINE_STRIDE);

    fetch_state_e      r_state;
    fetch_state_e      w_state_nx;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  w_wr_ptr_nx;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [ADDR_W-1:0] w_mem_addr_nx;
    logic [ADDR_W-1:0] r_line_addr;
    logic [ADDR_W-1:0] w_line_addr_nx;

    logic              r_vwin;
    logic              r_front;
    logic              r_swap_pend;
    logic              r_underrun;
    logic [PTR_W-1:0]  r_front_cnt;

    logic              r_hact;
    logic [PTR_W-1:0]  r_rd_cnt;
    logic              r_have_pix;
    logic              r_s1_v;
    logic              r_s1_new;
    logic              r_s1_border;
    logic              r_pix_de;
    logic [PIX_W-1:0]  r_pix_data;

    logic              w_vw_start;
    logic              w_vc_step;
    logic              w_trig;
    logic              w_ack;
    logic              w_swap;
    logic [PTR_W-1:0]  w_fill_cnt;
    logic              w_short;
    logic [IDX_W-1:0]  w_rd_idx;
    logic              w_rd_new;
    logic              w_rd_hold;
    logic              w_rd_border;
    logic [PIX_W-1:0]  w_ram_rdata;

    assign w_vw_start = i_ex_heav & i_ex_vwsav;
    assign w_vc_step  = i_ex_heav & ~i_ex_vwsav & r_vwin & i_ex_vc;
    assign w_trig     = w_vw_start | w_vc_step;
    assign w_ack      = (r_state == FS_FETCH) & i_mem_ack;
    // a new trigger in the same cycle keeps the swap pending for the restarted fetch
    assign w_swap     = i_ex_hwsav & r_swap_pend & ~w_trig;
    assign w_fill_cnt = r_wr_ptr + PTR_W'(w_ack);
    assign w_short    = (r_state == FS_FETCH) & (w_fill_cnt != HPIX_P);

    always_comb begin
        w_line_addr_nx = r_line_addr;
        if (w_vw_start) begin
            w_line_addr_nx = BASE_ADDR;
        end else if (w_vc_step) begin
            w_line_addr_nx = r_line_addr + STRIDE_A;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_wr_ptr_nx   = r_wr_ptr;
        w_mem_addr_nx = r_mem_addr;
        if (w_trig) begin
            w_state_nx    = FS_FETCH;
            w_wr_ptr_nx   = '0;
            w_mem_addr_nx = w_line_addr_nx;
        end else if (w_swap) begin
            w_state_nx  = FS_IDLE;
            w_wr_ptr_nx = w_fill_cnt;
        end else if (w_ack) begin
            w_wr_ptr_nx   = r_wr_ptr + 1'b1;
            w_mem_addr_nx = r_mem_addr + 1'b1;
            if (r_wr_ptr == LAST_P) begin
                w_state_nx = FS_DONE;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= FS_IDLE;
            r_wr_ptr    <= '0;
            r_mem_addr  <= '0;
            r_line_addr <= BASE_ADDR;
        end else begin
            r_state     <= w_state_nx;
            r_wr_ptr    <= w_wr_ptr_nx;
            r_mem_addr  <= w_mem_addr_nx;
            r_line_addr <= w_line_addr_nx;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vwin      <= 1'b0;
            r_front     <= BUF_A;
            r_swap_pend <= 1'b0;
            r_underrun  <= 1'b0;
            r_front_cnt <= '0;
        end else begin
            if (i_ex_veav) begin
                r_vwin <= 1'b0;
            end else if (i_ex_vwsav) begin
                r_vwin <= 1'b1;
            end
            if (w_trig) begin
                r_swap_pend <= 1'b1;
            end else if (w_swap) begin
                r_swap_pend <= 1'b0;
            end
            if (w_swap) begin
                r_front     <= ~r_front;
                r_front_cnt <= w_fill_cnt;
            end
            if (i_ex_vwsav) begin
                r_underrun <= 1'b0;
            end else if ((w_trig && r_state == FS_FETCH) || (w_swap && w_short)) begin
                r_underrun <= 1'b1;
            end
        end
    end

`ifdef LINE_FETCH_HFLIP_EN
    assign w_rd_idx = IDX_W'(LAST_P - r_rd_cnt);
`else
    assign w_rd_idx = r_rd_cnt[IDX_W-1:0];
`endif

    // r_rd_cnt reaching HPIX marks the line as fully read; the next dot enable ends it
    assign w_rd_new    = r_hact & i_ex_hc & (r_rd_cnt != HPIX_P);
    assign w_rd_hold   = r_hact & ~i_ex_hc & r_have_pix;
    assign w_rd_border = ({1'b0, w_rd_idx} >= r_front_cnt);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hact     <= 1'b0;
            r_rd_cnt   <= '0;
            r_have_pix <= 1'b0;
        end else if (i_ex_hwsav && r_vwin) begin
            r_hact     <= 1'b1;
            r_rd_cnt   <= '0;
            r_have_pix <= 1'b0;
        end else if (i_ex_heav) begin
            r_hact <= 1'b0;
        end else if (r_hact && i_ex_hc && r_rd_cnt == HPIX_P) begin
            r_hact <= 1'b0;
        end else if (w_rd_new) begin
            r_rd_cnt   <= r_rd_cnt + 1'b1;
            r_have_pix <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1_v      <= 1'b0;
            r_s1_new    <= 1'b0;
            r_s1_border <= 1'b0;
            r_pix_de    <= 1'b0;
            r_pix_data  <= BORDER;
        end else begin
            r_s1_v      <= w_rd_new | w_rd_hold;
            r_s1_new    <= w_rd_new;
            r_s1_border <= w_rd_border;
            if (r_s1_v) begin
                r_pix_de <= 1'b1;
                if (r_s1_new) begin
                    r_pix_data <= r_s1_border ? BORDER : w_ram_rdata;
                end
            end else begin
                r_pix_de   <= 1'b0;
                r_pix_data <= BORDER;
            end
        end
    end

    line_fetch_ram #(
        .PIX_W (PIX_W),
        .IDX_W (IDX_W)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_ack),
        .i_wsel  (~r_front),
        .i_widx  (r_wr_ptr[IDX_W-1:0]),
        .i_wdata (i_mem_rdata),
        .i_re    (w_rd_new),
        .i_rsel  (r_front),
        .i_ridx  (w_rd_idx),
        .o_rdata (w_ram_rdata)
    );

    assign o_mem_req  = (r_state == FS_FETCH);
    assign o_mem_addr = r_mem_addr;
    assign o_pix_de   = r_pix_de;
    assign o_pix_data = r_pix_data;
    assign o_underrun = r_underrun;

endmodule
